// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Single-clock FIFO with arbitrary (non power-of-two) capacity. Supports a
// standard registered-read mode and a first-word-fall-through mode. It exposes
// the fill level, programmable almost-full/almost-empty flags and sticky
// overflow/underflow error flags.
//
// Parameters
//   WIDTH        data bus width (>= 1)
//   CAPACITY     number of storable words (>= 1, any integer)
//   FWFT         0 = registered read, 1 = first-word-fall-through
//   AFULL_LEVEL  almost_full asserts when level >= AFULL_LEVEL
//   AEMPTY_LEVEL almost_empty asserts when level <= AEMPTY_LEVEL
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   wrena/wrdata write request and write data
//   rdena        read request (in FWFT mode this pops the visible head word)
//   rddata       read data
//   full/empty   level == CAPACITY / level == 0
//   almost_full  level >= AFULL_LEVEL
//   almost_empty level <= AEMPTY_LEVEL
//   level        stored word count
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync #(
    parameter int WIDTH        = 8,
    parameter int CAPACITY     = 16,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = CAPACITY - 1,
    parameter int AEMPTY_LEVEL = 1,
    localparam int CNT_WIDTH   = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrena,
    input  logic [WIDTH-1:0]     wrdata,
    input  logic                 rdena,
    output logic [WIDTH-1:0]     rddata,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [CNT_WIDTH-1:0] level,
    output logic                 overflow,
    output logic                 underflow
);

    // A one-word FIFO still needs a 1-bit pointer to keep the code uniform.
    localparam int PTR_WIDTH = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;

    localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(CAPACITY - 1);
    localparam logic [CNT_WIDTH-1:0] CAP_CNT    = CNT_WIDTH'(CAPACITY);
    localparam logic [CNT_WIDTH-1:0] AFULL_CNT  = CNT_WIDTH'(AFULL_LEVEL);
    localparam logic [CNT_WIDTH-1:0] AEMPTY_CNT = CNT_WIDTH'(AEMPTY_LEVEL);

    logic [WIDTH-1:0]     mem [CAPACITY];
    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_next;
    logic [CNT_WIDTH-1:0] level_reg;
    logic [CNT_WIDTH-1:0] level_next;
    logic                 overflow_reg;
    logic                 underflow_reg;
    logic                 wr_accept;
    logic                 rd_accept;

    // Pointers wrap explicitly at CAPACITY-1, so any capacity works.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Flags depend only on the level register: no path from wrena/rdena.
    assign full         = (level_reg == CAP_CNT);
    assign empty        = (level_reg == '0);
    assign almost_full  = (level_reg >= AFULL_CNT);
    assign almost_empty = (level_reg <= AEMPTY_CNT);
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Acceptance uses the pre-edge flags. A full FIFO never accepts a write,
    // even when a read is accepted in the same cycle, and an empty FIFO never
    // accepts a read alongside a write.
    assign wr_accept = wrena & ~full;
    assign rd_accept = rdena & ~empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (wr_accept) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (rd_accept) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({wr_accept, rd_accept})
            2'b10:   level_next = level_reg + CNT_WIDTH'(1);
            2'b01:   level_next = level_reg - CNT_WIDTH'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            if (wrena && full) begin
                overflow_reg <= 1'b1;
            end
            if (rdena && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // Storage is never cleared. Writes are blocked during reset so that a
    // discarded word cannot land at the freshly reset write pointer.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr_reg] <= wrdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is shown directly from the array at the read
            // pointer. When the FIFO is empty this shows a stale but stable
            // word.
            assign rddata = mem[rd_ptr_reg];
        end else begin : g_std
            logic [WIDTH-1:0] rddata_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rddata_reg <= '0;
                end else if (rd_accept) begin
                    rddata_reg <= mem[rd_ptr_reg];
                end
            end

            assign rddata = rddata_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync
// Self-checking bench for fifo_sync. It uses two instances that share one clock:
//   u_fifo_a : CAPACITY=99, standard registered read
//   u_fifo_b : CAPACITY=1, first-word-fall-through
// Each instance has a queue-based reference model. After every clock edge the
// bench compares all outputs against the model.
// -----------------------------------------------------------------------------
module tb_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: 99 words, standard read ----------------
    logic       a_rst, a_wrena, a_rdena;
    logic [7:0] a_wrdata, a_rddata;
    logic       a_full, a_empty, a_almost_full, a_almost_empty;
    logic [6:0] a_level;
    logic       a_overflow, a_underflow;

    fifo_sync #(.WIDTH(8), .CAPACITY(99), .FWFT(0)) u_fifo_a (
        .clk          (clk),
        .rst          (a_rst),
        .wrena        (a_wrena),
        .wrdata       (a_wrdata),
        .rdena        (a_rdena),
        .rddata       (a_rddata),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_almost_full),
        .almost_empty (a_almost_empty),
        .level        (a_level),
        .overflow     (a_overflow),
        .underflow    (a_underflow)
    );

    // ---------------- instance B: 1 word, FWFT ----------------
    logic       b_rst, b_wrena, b_rdena;
    logic [7:0] b_wrdata, b_rddata;
    logic       b_full, b_empty, b_almost_full, b_almost_empty;
    logic [0:0] b_level;
    logic       b_overflow, b_underflow;

    fifo_sync #(.WIDTH(8), .CAPACITY(1), .FWFT(1)) u_fifo_b (
        .clk          (clk),
        .rst          (b_rst),
        .wrena        (b_wrena),
        .wrdata       (b_wrdata),
        .rdena        (b_rdena),
        .rddata       (b_rddata),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_almost_full),
        .almost_empty (b_almost_empty),
        .level        (b_level),
        .overflow     (b_overflow),
        .underflow    (b_underflow)
    );

    // ---------------- reference models ----------------
    logic [7:0] qa[$];
    bit         a_ov, a_un;
    logic [7:0] a_exp_rd;

    logic [7:0] qb[$];
    bit         b_ov, b_un;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle on instance A. Inputs change at the falling edge and
    // outputs are checked at the next falling edge.
    task automatic cyc_a(input bit rst, input bit wr, input logic [7:0] d, input bit rd);
        int n;
        a_rst = rst; a_wrena = wr; a_wrdata = d; a_rdena = rd;
        @(posedge clk);
        n = qa.size();
        if (rst) begin
            qa.delete();
            a_ov = 0; a_un = 0; a_exp_rd = 8'h00;
        end else begin
            if (wr && n == 99) a_ov = 1;
            if (rd && n == 0)  a_un = 1;
            if (rd && n > 0)   a_exp_rd = qa.pop_front();
            if (wr && n < 99)  qa.push_back(d);
        end
        @(negedge clk);
        n = qa.size();
        check("a_level",    a_level,        n);
        check("a_empty",    a_empty,        n == 0);
        check("a_full",     a_full,         n == 99);
        check("a_afull",    a_almost_full,  n >= 98);
        check("a_aempty",   a_almost_empty, n <= 1);
        check("a_overflow", a_overflow,     a_ov);
        check("a_underflow",a_underflow,    a_un);
        check("a_rddata",   a_rddata,       a_exp_rd);
        $display("A rst=%0b wr=%0b d=%02h rd=%0b -> level=%0d rddata=%02h ov=%0b un=%0b",
                 rst, wr, d, rd, a_level, a_rddata, a_overflow, a_underflow);
    endtask

    task automatic cyc_b(input bit rst, input bit wr, input logic [7:0] d, input bit rd);
        int n;
        b_rst = rst; b_wrena = wr; b_wrdata = d; b_rdena = rd;
        @(posedge clk);
        n = qb.size();
        if (rst) begin
            qb.delete();
            b_ov = 0; b_un = 0;
        end else begin
            if (wr && n == 1) b_ov = 1;
            if (rd && n == 0) b_un = 1;
            if (rd && n > 0)  void'(qb.pop_front());
            if (wr && n < 1)  qb.push_back(d);
        end
        @(negedge clk);
        n = qb.size();
        check("b_level",    b_level,        n);
        check("b_empty",    b_empty,        n == 0);
        check("b_full",     b_full,         n == 1);
        check("b_afull",    b_almost_full,  1);
        check("b_aempty",   b_almost_empty, 1);
        check("b_overflow", b_overflow,     b_ov);
        check("b_underflow",b_underflow,    b_un);
        if (n > 0) check("b_rddata", b_rddata, qb[0]);
        $display("B rst=%0b wr=%0b d=%02h rd=%0b -> level=%0d rddata=%02h ov=%0b un=%0b",
                 rst, wr, d, rd, b_level, b_rddata, b_overflow, b_underflow);
    endtask

    initial begin
        int unsigned wp, rp;
        a_rst = 1'b1; a_wrena = 1'b0; a_wrdata = '0; a_rdena = 1'b0;
        b_rst = 1'b1; b_wrena = 1'b0; b_wrdata = '0; b_rdena = 1'b0;
        a_ov = 0; a_un = 0; a_exp_rd = '0;
        b_ov = 0; b_un = 0;
        @(negedge clk);

        // Reset held for two cycles.
        cyc_a(1, 0, 8'h00, 0);
        cyc_a(1, 0, 8'h00, 0);

        // Fill with 0..98, then a rejected 100th write.
        for (int i = 0; i < 99; i++) cyc_a(0, 1, 8'(i), 0);
        cyc_a(0, 1, 8'd99, 0);
        check("a_full_after_fill", a_full, 1'b1);

        // Drain in order, then an extra read to trigger underflow.
        for (int i = 0; i < 99; i++) cyc_a(0, 0, 8'h00, 1);
        check("a_last_word", a_rddata, 8'd98);
        cyc_a(0, 0, 8'h00, 1);

        // Hold the level at 50 with a concurrent write and read on each of
        // 990 cycles. This wraps the pointers ten times.
        for (int i = 0; i < 50; i++)  cyc_a(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 990; i++) cyc_a(0, 1, 8'($urandom), 1);
        check("a_level_50", a_level, 7'd50);

        // Reset at level 40 while both requests are asserted.
        for (int i = 0; i < 10; i++) cyc_a(0, 0, 8'h00, 1);
        check("a_level_40", a_level, 7'd40);
        cyc_a(1, 1, 8'($urandom), 1);
        cyc_a(0, 1, 8'h11, 0);
        cyc_a(0, 0, 8'h00, 1);
        check("a_rd_11", a_rddata, 8'h11);

        // Randomised traffic with drifting write/read bias and rare resets.
        for (int blk = 0; blk < 8; blk++) begin
            wp = $urandom_range(10, 95);
            rp = $urandom_range(10, 95);
            for (int i = 0; i < 250; i++)
                cyc_a($urandom_range(0, 299) == 0, $urandom_range(0, 99) < wp,
                      8'($urandom), $urandom_range(0, 99) < rp);
        end

        // FWFT with a one-word capacity.
        cyc_b(1, 0, 8'h00, 0);
        cyc_b(1, 0, 8'h00, 0);
        cyc_b(0, 1, 8'hA5, 0);
        check("b_rd_a5", b_rddata, 8'hA5);
        cyc_b(0, 1, 8'h3C, 1);
        check("b_empty_after_pop", b_empty, 1'b1);
        for (int i = 0; i < 500; i++)
            cyc_b($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                  8'($urandom), $urandom_range(0, 1) == 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
